// File: rtl/doodle_pkg.sv
// Shared doodle-game constants, platform table entry layout and collider FSM states.
package doodle_pkg;

  localparam int unsigned SCREEN_WIDTH = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned BLOCK_WIDTH = 40;
  localparam int unsigned BLOCK_HEIGHT = 5;
  localparam int unsigned COORD_W = 32;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               valid;
  } platform_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } scan_state_e;

endpackage

// File: rtl/platform_hit_test.sv
// Combinational landing test of a snapshotted doodle against one platform entry.
module platform_hit_test
  import doodle_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH  = 40,
  parameter int unsigned BLOCK_HEIGHT = 5,
  parameter int unsigned DOODLE_WIDTH = 20
) (
  input  logic [COORD_W-1:0] snap_x_i,
  input  logic [COORD_W-1:0] snap_y_i,
  input  logic               snap_falling_i,
  input  platform_t          entry_i,
  output logic               hit_c_o
);

  localparam int unsigned SUM_W = COORD_W + 1;

  logic [SUM_W-1:0] sx, sy, px, py;
  logic             y_ok, x_ok;

  // One extra bit keeps every sum free of wrap-around.
  assign sx = SUM_W'(snap_x_i);
  assign sy = SUM_W'(snap_y_i);
  assign px = SUM_W'(entry_i.x);
  assign py = SUM_W'(entry_i.y);

  assign y_ok = (py <= sy) && (sy <= py + SUM_W'(BLOCK_HEIGHT));
  assign x_ok = (sx + SUM_W'(DOODLE_WIDTH) > px) && (sx < px + SUM_W'(BLOCK_WIDTH));

  assign hit_c_o = entry_i.valid && snap_falling_i && y_ok && x_ok;

endmodule

// File: rtl/platform_collider.sv
// Platform table with a sequential, one-entry-per-clock collision scanner started by physics ticks.
module platform_collider
  import doodle_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS   = 8,
  parameter int unsigned BLOCK_WIDTH  = 40,
  parameter int unsigned BLOCK_HEIGHT = 5,
  parameter int unsigned DOODLE_WIDTH = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          physics_update,
  input  logic [COORD_W-1:0]            doodle_x,
  input  logic [COORD_W-1:0]            doodle_y,
  input  logic                          falling,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_BLOCKS)-1:0] wr_index,
  input  logic [COORD_W-1:0]            wr_x,
  input  logic [COORD_W-1:0]            wr_y,
  input  logic                          wr_valid,
  input  logic [$clog2(NUM_BLOCKS)-1:0] rd_index,
  output logic [COORD_W-1:0]            rd_x,
  output logic [COORD_W-1:0]            rd_y,
  output logic                          rd_valid,
  output logic                          has_collide,
  output logic [$clog2(NUM_BLOCKS)-1:0] collide_index,
  output logic                          scan_done
);

  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  platform_t          table_q [NUM_BLOCKS];
  scan_state_e        state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, hit_idx_q;
  logic               hit_q, pending_q, pending_d, phys_prev_q;
  logic [COORD_W-1:0] snap_x_q, snap_y_q;
  logic               snap_falling_q;
  logic               start_c, last_c, snap_load_c, test_c, publish_c, entry_hit_c;

  assign start_c = physics_update && !phys_prev_q;
  assign last_c  = (ptr_q == LAST_IDX);

  platform_hit_test #(
    .BLOCK_WIDTH  (BLOCK_WIDTH),
    .BLOCK_HEIGHT (BLOCK_HEIGHT),
    .DOODLE_WIDTH (DOODLE_WIDTH)
  ) u_hit (
    .snap_x_i       (snap_x_q),
    .snap_y_i       (snap_y_q),
    .snap_falling_i (snap_falling_q),
    .entry_i        (table_q[ptr_q]),
    .hit_c_o        (entry_hit_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_c) state_d = ST_SCAN;
      ST_SCAN:   if (last_c) state_d = ST_REPORT;
      ST_REPORT: state_d = (pending_q || start_c) ? ST_SCAN : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A tick arriving in REPORT is started immediately along with any pending one.
  always_comb begin
    snap_load_c = 1'b0;
    test_c      = 1'b0;
    publish_c   = 1'b0;
    pending_d   = pending_q;
    case (state_q)
      ST_IDLE:   snap_load_c = start_c;
      ST_SCAN: begin
        test_c    = 1'b1;
        publish_c = last_c;
        pending_d = pending_q || start_c;
      end
      ST_REPORT: begin
        snap_load_c = pending_q || start_c;
        pending_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Table storage and renderer read port; reads see pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) table_q[i].valid <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) table_q[wr_index] <= '{x: wr_x, y: wr_y, valid: wr_valid};
      rd_x     <= table_q[rd_index].x;
      rd_y     <= table_q[rd_index].y;
      rd_valid <= table_q[rd_index].valid;
    end
  end

  // Scanner datapath; results publish on the last test so they show in the REPORT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      phys_prev_q    <= 1'b1;
      pending_q      <= 1'b0;
      ptr_q          <= '0;
      hit_q          <= 1'b0;
      hit_idx_q      <= '0;
      snap_x_q       <= '0;
      snap_y_q       <= '0;
      snap_falling_q <= 1'b0;
      has_collide    <= 1'b0;
      collide_index  <= '0;
      scan_done      <= 1'b0;
    end else begin
      phys_prev_q <= physics_update;
      pending_q   <= pending_d;
      scan_done   <= publish_c;
      if (snap_load_c) begin
        snap_x_q       <= doodle_x;
        snap_y_q       <= doodle_y;
        snap_falling_q <= falling;
        ptr_q          <= '0;
        hit_q          <= 1'b0;
        hit_idx_q      <= '0;
      end else if (test_c) begin
        ptr_q <= ptr_q + IDX_W'(1);
        if (entry_hit_c && !hit_q) begin
          hit_q     <= 1'b1;
          hit_idx_q <= ptr_q;
        end
      end
      if (publish_c) begin
        has_collide   <= hit_q || entry_hit_c;
        collide_index <= hit_q ? hit_idx_q : (entry_hit_c ? ptr_q : '0);
      end
    end
  end

endmodule

// File: tb/tb_platform_collider.sv
// Directed scoreboard bench for platform_collider: landing edges, priority, merged ticks, reset abort.
module tb_platform_collider;

  logic        clk = 1'b0;
  logic        reset;
  logic        physics_update;
  logic [31:0] doodle_x, doodle_y;
  logic        falling;
  logic        wr_en;
  logic [2:0]  wr_index;
  logic [31:0] wr_x, wr_y;
  logic        wr_valid;
  logic [2:0]  rd_index;
  logic [31:0] rd_x, rd_y;
  logic        rd_valid;
  logic        has_collide;
  logic [2:0]  collide_index;
  logic        scan_done;

  typedef struct {
    logic       hit;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  platform_collider #(
    .NUM_BLOCKS   (8),
    .BLOCK_WIDTH  (40),
    .BLOCK_HEIGHT (5),
    .DOODLE_WIDTH (20)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .physics_update (physics_update),
    .doodle_x       (doodle_x),
    .doodle_y       (doodle_y),
    .falling        (falling),
    .wr_en          (wr_en),
    .wr_index       (wr_index),
    .wr_x           (wr_x),
    .wr_y           (wr_y),
    .wr_valid       (wr_valid),
    .rd_index       (rd_index),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .rd_valid       (rd_valid),
    .has_collide    (has_collide),
    .collide_index  (collide_index),
    .scan_done      (scan_done)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] x, input logic [31:0] y, input logic v);
    wr_en = 1'b1; wr_index = idx; wr_x = x; wr_y = y; wr_valid = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input logic h, input logic [2:0] i);
    exp_t e;
    e.hit = h;
    e.idx = i;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " has_collide"}, 32'(has_collide), 32'(e.hit));
      check({tag, " collide_index"}, 32'(collide_index), 32'(e.idx));
    end
  endtask

  // Edge cycle is the current cycle; result expected exactly 9 cycles later.
  task automatic run_scan(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic f, input logic eh, input logic [2:0] ei);
    int n;
    doodle_x = x; doodle_y = y; falling = f;
    physics_update = 1'b1;
    push_exp(eh, ei);
    n = 0;
    do begin
      tick();
      n++;
      physics_update = 1'b0;
    end while (!scan_done && n < 20);
    check({tag, " latency"}, 32'(n), 32'd9);
    pop_check(tag);
    tick();
    check({tag, " done_pulse_width"}, 32'(scan_done), 32'd0);
    tick();
  endtask

  initial begin
    int c, pulses, first_at, second_at;
    reset = 1'b1; physics_update = 1'b0; doodle_x = '0; doodle_y = '0; falling = 1'b0;
    wr_en = 1'b0; wr_index = '0; wr_x = '0; wr_y = '0; wr_valid = 1'b0; rd_index = '0;
    tick(); tick(); tick();
    check("reset has_collide", 32'(has_collide), 32'd0);
    check("reset collide_index", 32'(collide_index), 32'd0);
    check("reset scan_done", 32'(scan_done), 32'd0);
    check("reset rd_x", rd_x, 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("no spurious scan_done", 32'(scan_done), 32'd0);

    wr(3'd3, 32'd100, 32'd50, 1'b1);
    rd_index = 3'd3;
    tick();
    check("read x", rd_x, 32'd100);
    check("read y", rd_y, 32'd50);
    check("read valid", 32'(rd_valid), 32'd1);

    run_scan("basic hit", 32'd110, 32'd52, 1'b1, 1'b1, 3'd3);
    run_scan("not falling", 32'd110, 32'd52, 1'b0, 1'b0, 3'd0);
    run_scan("y=50", 32'd110, 32'd50, 1'b1, 1'b1, 3'd3);
    run_scan("y=55", 32'd110, 32'd55, 1'b1, 1'b1, 3'd3);
    run_scan("y=56", 32'd110, 32'd56, 1'b1, 1'b0, 3'd0);
    run_scan("y=49", 32'd110, 32'd49, 1'b1, 1'b0, 3'd0);
    run_scan("x=80", 32'd80, 32'd52, 1'b1, 1'b0, 3'd0);
    run_scan("x=81", 32'd81, 32'd52, 1'b1, 1'b1, 3'd3);
    run_scan("x=139", 32'd139, 32'd52, 1'b1, 1'b1, 3'd3);
    run_scan("x=140", 32'd140, 32'd52, 1'b1, 1'b0, 3'd0);

    // Priority: lowest valid hit wins.
    wr(3'd3, 32'd100, 32'd50, 1'b0);
    wr(3'd2, 32'd95, 32'd50, 1'b1);
    wr(3'd5, 32'd90, 32'd50, 1'b1);
    run_scan("two hits", 32'd110, 32'd52, 1'b1, 1'b1, 3'd2);
    wr(3'd2, 32'd95, 32'd50, 1'b0);
    run_scan("entry2 cleared", 32'd110, 32'd52, 1'b1, 1'b1, 3'd5);

    // Second tick mid-scan: two results, second one from the REPORT-cycle snapshot.
    doodle_x = 32'd110; doodle_y = 32'd52; falling = 1'b1;
    physics_update = 1'b1;
    push_exp(1'b1, 3'd5);
    c = 0; pulses = 0; first_at = 0; second_at = 0;
    while (c < 40) begin
      tick();
      c++;
      physics_update = (c == 3);
      if (c == 3) begin
        doodle_y = 32'd100;
        push_exp(1'b0, 3'd0);
      end
      if (scan_done) begin
        pulses++;
        if (pulses == 1) first_at = c;
        if (pulses == 2) second_at = c;
        pop_check("merged tick");
      end
    end
    check("merged pulse count", 32'(pulses), 32'd2);
    check("merged first at", 32'(first_at), 32'd9);
    check("merged second at", 32'(second_at), 32'd18);

    // Reset mid-scan after a prior hit is on the outputs.
    run_scan("pre-abort hit", 32'd110, 32'd52, 1'b1, 1'b1, 3'd5);
    physics_update = 1'b1;
    c = 0; pulses = 0;
    while (c < 20) begin
      tick();
      c++;
      physics_update = 1'b0;
      reset = (c == 4 || c == 5);
      if (scan_done) pulses++;
    end
    check("aborted scan_done count", 32'(pulses), 32'd0);
    check("aborted has_collide", 32'(has_collide), 32'd0);
    check("aborted collide_index", 32'(collide_index), 32'd0);
    rd_index = 3'd5;
    tick();
    check("entry5 invalid after reset", 32'(rd_valid), 32'd0);
    run_scan("after reset", 32'd110, 32'd52, 1'b1, 1'b0, 3'd0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
